// File: rtl/pwd_pkg.sv
// rtl/pwd_pkg.sv - shared PWM encodings and defaults for the pwdControl/pwd_capture pair
package pwd_pkg;

  localparam int PWD_COUNTER_WIDTH = 8;
  localparam int PWD_MAX_COUNT     = 200;
  localparam int PWD_SYNC_STAGES   = 2;

  localparam logic [1:0] ST_SEEK = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } pwd_edge_t;

endpackage

// File: rtl/pwd_edge_sync.sv
// rtl/pwd_edge_sync.sv - metastability chain plus single-bit edge detect for an async PWM pin
module pwd_edge_sync
  import pwd_pkg::*;
#(
  parameter int SYNC_STAGES = PWD_SYNC_STAGES
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  logic      pwd_i,
  output pwd_edge_t edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_dly_q;
  logic                   level;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pwd_i};
      level_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level       = sync_q[SYNC_STAGES-1];
  assign edge_o.level = level;
  assign edge_o.rise  = level & ~level_dly_q;
  assign edge_o.fall  = ~level & level_dly_q;

endmodule

// File: rtl/pwd_capture.sv
// rtl/pwd_capture.sv - measures period and high time of an incoming PWM waveform in clk_in cycles
// and flags a stuck line when no expected edge arrives within MAX_COUNT cycles.
module pwd_capture
  import pwd_pkg::*;
#(
  parameter int COUNTER_WIDTH = PWD_COUNTER_WIDTH,
  parameter int MAX_COUNT     = PWD_MAX_COUNT,
  parameter int SYNC_STAGES   = PWD_SYNC_STAGES
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     pwd_in,
  output logic [COUNTER_WIDTH-1:0] period_out,
  output logic [COUNTER_WIDTH-1:0] high_out,
  output logic                     valid_out,
  output logic                     timeout_out,
  output logic                     level_out
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_CNT = COUNTER_WIDTH'(MAX_COUNT);
  localparam logic [COUNTER_WIDTH-1:0] ONE_CNT = COUNTER_WIDTH'(1);

  pwd_edge_t edge_s;

  logic [1:0]               state_q,   state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q,     cnt_d;
  logic [COUNTER_WIDTH-1:0] hi_q,      hi_d;
  logic [COUNTER_WIDTH-1:0] period_q,  period_d;
  logic [COUNTER_WIDTH-1:0] high_q,    high_d;
  logic                     valid_q,   valid_d;
  logic                     timeout_q, timeout_d;
  logic                     level_q,   level_d;
  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     at_max;

  pwd_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .pwd_i   (pwd_in),
    .edge_o  (edge_s)
  );

  // Saturate so a fall landing exactly on MAX_COUNT cannot wrap the count in LOW.
  assign at_max  = (cnt_q == MAX_CNT);
  assign cnt_inc = at_max ? cnt_q : cnt_q + ONE_CNT;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    level_d   = level_q;

    case (state_q)
      ST_SEEK: begin
        if (edge_s.rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_CNT;
        end
      end

      ST_HIGH: begin
        if (edge_s.fall) begin
          hi_d    = cnt_q;
          state_d = ST_LOW;
          cnt_d   = cnt_inc;
        end else if (at_max) begin
          state_d   = ST_SEEK;
          timeout_d = 1'b1;
          level_d   = edge_s.level;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LOW: begin
        // The expected edge wins over a timeout landing in the same cycle.
        if (edge_s.rise) begin
          period_d  = cnt_q;
          high_d    = hi_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = ONE_CNT;
          state_d   = ST_HIGH;
        end else if (at_max) begin
          state_d   = ST_SEEK;
          timeout_d = 1'b1;
          level_d   = edge_s.level;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_SEEK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_SEEK;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      level_q   <= level_d;
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign valid_out   = valid_q;
  assign timeout_out = timeout_q;
  assign level_out   = level_q;

endmodule

// File: tb/tb_pwd_capture.sv
// tb/tb_pwd_capture.sv - directed scoreboard bench for pwd_capture
module tb_pwd_capture;

  typedef struct packed {
    logic [7:0] period;
    logic [7:0] high;
  } meas_t;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       pwd_in = 1'b0;
  logic [7:0] period_out;
  logic [7:0] high_out;
  logic       valid_out;
  logic       timeout_out;
  logic       level_out;

  int    n_checks = 0;
  int    n_fails  = 0;
  meas_t exp_q[$];

  logic  pend = 1'b0;
  meas_t pend_m;

  pwd_capture #(
    .COUNTER_WIDTH(8),
    .MAX_COUNT    (200),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .pwd_in     (pwd_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid_out  (valid_out),
    .timeout_out(timeout_out),
    .level_out  (level_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One full PWM period starting with a rise; the rise closes the previous period's measurement.
  task automatic wave(input int h, input int l);
    if (pend) exp_q.push_back(pend_m);
    pwd_in = 1'b1;
    repeat (h) @(negedge clk_in);
    pwd_in = 1'b0;
    repeat (l) @(negedge clk_in);
    pend          = 1'b1;
    pend_m.period = 8'(h + l);
    pend_m.high   = 8'(h);
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && valid_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(valid_out), 32'd0);
      end else begin
        meas_t m;
        m = exp_q.pop_front();
        check("period_out", 32'(period_out), 32'(m.period));
        check("high_out", 32'(high_out), 32'(m.high));
        check("timeout_at_valid", 32'(timeout_out), 32'd0);
      end
    end
  end

  initial begin
    rst_n_in = 1'b0;
    pwd_in   = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_period", 32'(period_out), 32'd0);
    check("rst_high", 32'(high_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);
    check("rst_level", 32'(level_out), 32'd0);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    repeat (4) wave(30, 70);

    // Stuck high after a rise: measurement of the last 30/70 completes, then timeout.
    if (pend) exp_q.push_back(pend_m);
    pend   = 1'b0;
    pwd_in = 1'b1;
    repeat (250) @(negedge clk_in);
    check("stuck_hi_timeout", 32'(timeout_out), 32'd1);
    check("stuck_hi_level", 32'(level_out), 32'd1);
    check("hold_period", 32'(period_out), 32'd100);
    check("hold_high", 32'(high_out), 32'd30);
    check("queue_after_stuck", 32'(exp_q.size()), 32'd0);

    pwd_in = 1'b0;
    repeat (10) @(negedge clk_in);
    wave(50, 50);
    check("timeout_sticky_seek", 32'(timeout_out), 32'd1);
    wave(50, 50);
    wave(50, 50);
    check("timeout_cleared", 32'(timeout_out), 32'd0);

    wave(100, 100);
    wave(100, 100);
    check("boundary_no_timeout", 32'(timeout_out), 32'd0);

    repeat (4) wave(1, 1);

    wave(30, 70);
    wave(30, 70);
    wave(60, 40);
    wave(60, 40);
    wave(30, 70);

    // Rise closes the pending period, then reset lands mid-HIGH.
    if (pend) exp_q.push_back(pend_m);
    pend   = 1'b0;
    pwd_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check("queue_before_reset", 32'(exp_q.size()), 32'd0);
    #2 rst_n_in = 1'b0;
    pwd_in = 1'b0;
    #1;
    check("async_rst_period", 32'(period_out), 32'd0);
    check("async_rst_high", 32'(high_out), 32'd0);
    check("async_rst_timeout", 32'(timeout_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (10) @(negedge clk_in);
    wave(40, 60);
    check("no_valid_after_one_rise", 32'(period_out), 32'd0);
    wave(45, 55);

    // Stuck low: last wave's period never completes, timeout latches level 0.
    pwd_in = 1'b0;
    pend   = 1'b0;
    repeat (300) @(negedge clk_in);
    check("stuck_lo_timeout", 32'(timeout_out), 32'd1);
    check("stuck_lo_level", 32'(level_out), 32'd0);
    check("stuck_lo_hold_period", 32'(period_out), 32'd100);
    check("stuck_lo_hold_high", 32'(high_out), 32'd40);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
